// File: rtl/cutelock_serial_adder.sv
// cutelock_serial_adder
//   Key-locked bit-serial adder. Two operands arrive LSB first, one bit per
//   enabled cycle, in frames of FRAME_LEN bits. A free-running key counter
//   selects one KEY_TABLE entry per cycle. If the presented key does not match
//   that entry, the sum bit is inverted. The carry into the next bit is also
//   flipped, so the corruption spreads through the rest of the frame.
//
// Ports
//   clock       in   1      rising-edge clock
//   reset       in   1      synchronous, active-high; clears all state
//   EN          in   1      LINE1/LINE2 carry a valid bit this cycle
//   LINE1       in   1      operand A serial bit, LSB first
//   LINE2       in   1      operand B serial bit, LSB first
//   keyinput    in   KEY_W  unlock key, sampled every cycle
//   OUTP_REG    out  1      registered sum bit
//   OVERFLW_REG out  1      registered one-cycle end-of-frame carry-out pulse

module cutelock_serial_adder #(
   parameter int unsigned FRAME_LEN = 4,
   parameter int unsigned KEY_W     = 3,
   parameter int unsigned NUM_KEYS  = 4,
   parameter logic [NUM_KEYS*KEY_W-1:0] KEY_TABLE = 12'hF5E
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             EN,
   input  logic             LINE1,
   input  logic             LINE2,
   input  logic [KEY_W-1:0] keyinput,
   output logic             OUTP_REG,
   output logic             OVERFLW_REG
);

   localparam int unsigned CNT_W = (NUM_KEYS  > 1) ? $clog2(NUM_KEYS)  : 1;
   localparam int unsigned IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   localparam logic [CNT_W-1:0] KeyLast = CNT_W'(NUM_KEYS - 1);
   localparam logic [IDX_W-1:0] IdxLast = IDX_W'(FRAME_LEN - 1);

   logic [CNT_W-1:0] key_cnt_q, key_cnt_d;
   logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
   logic             carry_q,   carry_d;
   logic             outp_d,    ovf_d;

   logic [KEY_W-1:0] key_entry;
   logic             key_ok;
   logic             sum_bit;
   logic             carry_gen;
   logic             carry_locked;
   logic             last_bit;

   // The key schedule runs on every cycle, whether or not a bit is being added.
   always_comb begin
      key_cnt_d = (key_cnt_q == KeyLast) ? '0 : key_cnt_q + 1'b1;
   end

   always_comb begin
      key_entry    = KEY_TABLE[int'(key_cnt_q) * KEY_W +: KEY_W];
      key_ok       = (keyinput == key_entry);
      sum_bit      = LINE1 ^ LINE2 ^ carry_q;
      carry_gen    = (LINE1 & LINE2) | (LINE1 & carry_q) | (LINE2 & carry_q);
      // A wrong key flips the carry, so later bits of this frame stay corrupted.
      carry_locked = carry_gen ^ ~key_ok;
      last_bit     = (bit_idx_q == IdxLast);
   end

   always_comb begin
      carry_d   = carry_q;
      bit_idx_d = bit_idx_q;
      outp_d    = OUTP_REG;
      ovf_d     = 1'b0;
      if (EN) begin
         outp_d = key_ok ? sum_bit : ~sum_bit;
         if (last_bit) begin
            // The frame ends here. The carry goes out as the overflow pulse,
            // and the next bit starts a fresh frame with a zero carry.
            ovf_d     = carry_locked;
            carry_d   = 1'b0;
            bit_idx_d = '0;
         end else begin
            carry_d   = carry_locked;
            bit_idx_d = bit_idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         key_cnt_q   <= '0;
         bit_idx_q   <= '0;
         carry_q     <= 1'b0;
         OUTP_REG    <= 1'b0;
         OVERFLW_REG <= 1'b0;
      end else begin
         key_cnt_q   <= key_cnt_d;
         bit_idx_q   <= bit_idx_d;
         carry_q     <= carry_d;
         OUTP_REG    <= outp_d;
         OVERFLW_REG <= ovf_d;
      end
   end

endmodule

// File: tb/tb_cutelock_serial_adder.sv
// tb_cutelock_serial_adder
//   Bench for cutelock_serial_adder. A behavioural model inside the bench does
//   the frame arithmetic with integer sums. Directed frames are also checked
//   against fixed expected vectors.

module tb_cutelock_serial_adder;

   localparam int unsigned FRAME_LEN = 4;
   localparam int unsigned KEY_W     = 3;
   localparam int unsigned NUM_KEYS  = 4;
   localparam logic [NUM_KEYS*KEY_W-1:0] KEY_TABLE = 12'hF5E;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             EN    = 1'b0;
   logic             LINE1 = 1'b0;
   logic             LINE2 = 1'b0;
   logic [KEY_W-1:0] keyinput = '0;
   logic             OUTP_REG;
   logic             OVERFLW_REG;

   int n_checks = 0;
   int n_errors = 0;

   // Model state.
   int   m_q     = 0;
   int   m_idx   = 0;
   int   m_carry = 0;
   logic m_outp  = 1'b0;
   logic m_ovf   = 1'b0;

   cutelock_serial_adder #(
      .FRAME_LEN (FRAME_LEN),
      .KEY_W     (KEY_W),
      .NUM_KEYS  (NUM_KEYS),
      .KEY_TABLE (KEY_TABLE)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .EN          (EN),
      .LINE1       (LINE1),
      .LINE2       (LINE2),
      .keyinput    (keyinput),
      .OUTP_REG    (OUTP_REG),
      .OVERFLW_REG (OVERFLW_REG)
   );

   always #5 clock = ~clock;

   function automatic logic [KEY_W-1:0] entry(input int k);
      logic [NUM_KEYS*KEY_W-1:0] tbl;
      tbl = KEY_TABLE;
      return tbl[k*KEY_W +: KEY_W];
   endfunction

   task automatic check_bit(input string tag, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Drive one cycle, advance the model across the edge, then compare.
   task automatic step(input string tag, input logic rst, input logic en,
                       input logic a, input logic b, input logic [KEY_W-1:0] key);
      int   sum;
      int   cc;
      logic ok;
      @(negedge clock);
      reset = rst; EN = en; LINE1 = a; LINE2 = b; keyinput = key;
      @(posedge clock);
      if (rst) begin
         m_q = 0; m_idx = 0; m_carry = 0; m_outp = 1'b0; m_ovf = 1'b0;
      end else begin
         ok    = (key == entry(m_q));
         m_ovf = 1'b0;
         if (en) begin
            sum    = int'(a) + int'(b) + m_carry;
            m_outp = ok ? logic'(sum % 2) : !logic'(sum % 2);
            cc     = (sum / 2) ^ (ok ? 0 : 1);
            if (m_idx == FRAME_LEN - 1) begin
               m_ovf   = logic'(cc);
               m_carry = 0;
               m_idx   = 0;
            end else begin
               m_carry = cc;
               m_idx   = m_idx + 1;
            end
         end
         m_q = (m_q + 1) % NUM_KEYS;
      end
      #1;
      check_bit({tag, "_outp"}, OUTP_REG, m_outp);
      check_bit({tag, "_ovf"}, OVERFLW_REG, m_ovf);
   endtask

   // One full frame. A bit set in wrong_mask presents a bad key on that bit.
   // When lit is set, the outputs are also compared with exp_o/exp_v.
   task automatic frame(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] wrong_mask, input logic lit,
                        input logic [3:0] exp_o, input logic [3:0] exp_v);
      logic [KEY_W-1:0] key;
      for (int i = 0; i < 4; i++) begin
         key = entry(m_q);
         if (wrong_mask[i]) key = key ^ 3'b001;
         step($sformatf("%s_b%0d", tag, i), 1'b0, 1'b1, a[i], b[i], key);
         if (lit) begin
            check_bit($sformatf("%s_lit_o%0d", tag, i), OUTP_REG, exp_o[i]);
            check_bit($sformatf("%s_lit_v%0d", tag, i), OVERFLW_REG, exp_v[i]);
         end
      end
   endtask

   initial begin
      logic [3:0] av, bv;
      logic       r, e;
      logic [KEY_W-1:0] k;

      // Reset state.
      step("rst0", 1'b1, 1'b1, 1'b1, 1'b1, '0);
      step("rst1", 1'b1, 1'b1, 1'b1, 1'b1, '0);
      check_bit("rst_outp_zero", OUTP_REG, 1'b0);
      check_bit("rst_ovf_zero", OVERFLW_REG, 1'b0);

      // Correct-key frame.
      frame("good", 4'b1111, 4'b0001, 4'b0000, 1'b1, 4'b0000, 4'b1000);
      step("good_idle", 1'b0, 1'b0, 1'b0, 1'b0, entry(m_q));
      check_bit("good_idle_ovf_lo", OVERFLW_REG, 1'b0);

      // Wrong key throughout (no table entry is zero).
      frame("wrong", 4'b0000, 4'b0000, 4'b1111, 1'b1, 4'b0001, 4'b1000);

      // A bad key on bit 1 only, then a clean frame.
      frame("mis1", 4'b0000, 4'b0000, 4'b0010, 1'b0, 4'b0000, 4'b0000);
      frame("clean", 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000);

      // The correct-key frame with a three-cycle EN gap between bits 1 and 2.
      av = 4'b1111; bv = 4'b0001;
      for (int i = 0; i < 2; i++) step("gap_pre", 1'b0, 1'b1, av[i], bv[i], entry(m_q));
      for (int g = 0; g < 3; g++) begin
         step("gap_idle", 1'b0, 1'b0, 1'b1, 1'b0, entry(m_q));
         check_bit("gap_outp_held", OUTP_REG, 1'b0);
         check_bit("gap_ovf_lo", OVERFLW_REG, 1'b0);
      end
      for (int i = 2; i < 4; i++) step("gap_post", 1'b0, 1'b1, av[i], bv[i], entry(m_q));
      check_bit("gap_final_ovf", OVERFLW_REG, 1'b1);

      // Reset mid-frame, then a fresh frame with A = B = 0001.
      for (int i = 0; i < 3; i++) step("mid_pre", 1'b0, 1'b1, 1'b1, 1'b1, entry(m_q));
      step("mid_rst", 1'b1, 1'b1, 1'b1, 1'b1, '0);
      check_bit("mid_rst_outp", OUTP_REG, 1'b0);
      check_bit("mid_rst_ovf", OVERFLW_REG, 1'b0);
      frame("fresh", 4'b0001, 4'b0001, 4'b0000, 1'b1, 4'b0010, 4'b0000);

      // Key-counter wrap: after reset, cycle k must accept entry (k mod 4).
      step("wrap_rst", 1'b1, 1'b0, 1'b0, 1'b0, '0);
      for (int kc = 0; kc < 9; kc++) begin
         step($sformatf("wrap%0d", kc), 1'b0, 1'b1, 1'b0, 1'b0, entry(kc % NUM_KEYS));
         check_bit($sformatf("wrap%0d_lit_o", kc), OUTP_REG, 1'b0);
         check_bit($sformatf("wrap%0d_lit_v", kc), OVERFLW_REG, 1'b0);
      end

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         r = ($urandom_range(0, 49) == 0);
         e = ($urandom_range(0, 3) != 0);
         k = ($urandom_range(0, 3) != 0) ? entry(m_q) : KEY_W'($urandom);
         step("rand", r, e, logic'($urandom), logic'($urandom), k);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
